inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage of the single-cycle RISC-V demo core. Sits directly upstream of the 32×1024 instruction ROM: holds the PC, drives the ROM word address, and absorbs the ROM's one-cycle registered read latency. Delivers {pc, instruction} pairs to decode over a valid/ready handshake, with backpressure and branch/jump redirect. RV32I only, no compressed instructions.

## Interface
- ADDR_WIDTH, 10, ROM word-address width; must match the ROM.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

- clk  in  1  core clock, shared with the ROM.
- rst  in  1  reset, synchronous, active-low. The ROM's own active-high `rst` is driven from `~rst` at top level.
- rom_addr  out  ADDR_WIDTH  ROM word address, driven directly from a register.
- rom_rd_data  in  DATA_WIDTH  ROM read data for the address sampled at the previous edge.
- redirect_valid  in  1  load a new PC and flush (branch/jump/trap).
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- id_valid  out  1  an instruction is offered to decode.
- id_ready  in  1  decode accepts; a transfer occurs when id_valid and id_ready are both high at an edge.
- id_pc  out  32  PC of the offered instruction.
- id_inst  out  DATA_WIDTH  offered instruction.

## Operation
- State:
  - fetch_pc (32 b), the byte address currently presented to the ROM.
  - resp_live (1 b), set when the ROM output this cycle belongs to a live fetch.
  - resp_pc (32 b), the PC of that ROM output.
  - A 2-entry output FIFO of {pc, inst} with count 0..2.
- rom_addr = fetch_pc[ADDR_WIDTH+1:2]. PC bits above ADDR_WIDTH+1 are not decoded, so the ROM aliases.
- id_valid, id_pc and id_inst come from the FIFO head and are fully registered.
- pop = id_valid & id_ready.
- Write: at each edge where resp_live = 1, {resp_pc, rom_rd_data} is pushed into the FIFO.
- Credit (issue) rule:
  - count_next = count + resp_live − pop.
  - Issue iff count_next ≤ 1.
  - Issue: resp_live ← 1, resp_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (32-bit wrap).
  - No issue: resp_live ← 0; fetch_pc holds.
  - Consequence: the FIFO never overflows. A push while count = 2 is a design error and must be asserted against.
- Redirect (priority over everything except reset), at any edge with redirect_valid = 1:
  - FIFO count ← 0.
  - resp_live ← 0; the in-flight ROM response is discarded.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - A pop in the same cycle is ignored.
  - No issue occurs at that edge.
- Reset (rst = 0 at an edge):
  - fetch_pc ← RESET_PC, resp_live ← 0, count ← 0, FIFO entries ← 0.
  - rom_rd_data is ignored while resp_live = 0, so ROM X/garbage never reaches decode.

## Timing
- Reset values:
  - id_valid = 0, id_pc = 0, id_inst = 0.
  - rom_addr = RESET_PC[ADDR_WIDTH+1:2].
- Cold-start latency:
  - Cycle 0 is the first cycle with rst = 1; rom_addr = RESET_PC. Issue happens at the end of cycle 0.
  - Cycle 1: ROM data valid; pushed at the end of cycle 1.
  - Cycle 2: id_valid = 1 with id_pc = RESET_PC.
- Throughput: one instruction per cycle when id_ready stays high (steady state count = 1).
- Backpressure:
  - When id_ready drops, fetch_pc stops advancing within one edge.
  - At most 2 instructions are buffered; none are lost or duplicated.
  - id_pc and id_inst hold stable while id_valid = 1 and id_ready = 0.
  - After id_ready rises, the stream resumes contiguously at one instruction per cycle.
- Redirect penalty: redirect at edge E0 gives id_valid = 0 during cycles 1–2 and the target instruction in cycle 3 (3 cycles).
- Redirect held high for multiple cycles: each edge re-flushes and reloads; fetch resumes after the last one.
- Reset mid-operation: one low cycle fully reinitialises; the stream restarts at RESET_PC with cold-start latency.

## Test plan
- ROM model: mem[i] = 32'h100 + i, ROM latency 1, RESET_PC = 0.
- Cold start / stream: rst low 3 cycles, id_ready = 1.
  - Response: id_valid rises exactly 2 cycles after release.
  - (id_pc, id_inst) = (0, 0x100), (4, 0x101), (8, 0x102)… on consecutive cycles.
- Backpressure: id_ready low for 5 cycles while id_pc = 0x10.
  - Response: id_pc/id_inst hold 0x10/0x104 throughout and rom_addr advances by ≤ 2 words.
  - After release: 0x10, 0x14, 0x18… with no gaps or repeats.
- Redirect: redirect_valid = 1, redirect_pc = 0x43 at the edge while id_pc = 0x8.
  - Response: id_valid = 0 for the following 2 cycles.
  - Then id_pc = 0x40, id_inst = 0x110, then 0x44 / 0x111.
- Redirect while full: id_ready = 0 with the FIFO holding 2 entries, then redirect to 0x20 together with id_ready = 1.
  - Response: neither old entry is delivered; next delivery is 0x20 / 0x108.
- Wrap: RESET_PC = 0xFF8, ADDR_WIDTH = 10.
  - rom_addr sequence: 0x3FE, 0x3FF, 0x000.
  - id_pc sequence: 0xFF8, 0xFFC, 0x1000.
  - id_inst sequence: 0x4FE, 0x4FF, 0x100.
- Reset mid-run: FIFO full with id_ready = 0, then rst low for one cycle.
  - Response: id_valid = 0 on the next cycle.
  - Restart: id_pc = 0 two cycles after release; no stale entries appear.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the registered-read ROM, and hands
// {pc, inst} pairs to decode through a 2-entry credit-controlled output FIFO.
module inst_fetch #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_rd_data_i,
    input  logic                  redirect_valid_i,
    input  logic [31:0]           redirect_pc_i,
    output logic                  id_valid_o,
    input  logic                  id_ready_i,
    output logic [31:0]           id_pc_o,
    output logic [DATA_WIDTH-1:0] id_inst_o
);

    logic [31:0]           fetch_pc_q, fetch_pc_d;
    logic                  resp_live_q, resp_live_d;
    logic [31:0]           resp_pc_q, resp_pc_d;
    logic [1:0]            count_q, count_d;
    logic                  valid_q, valid_d;
    logic [31:0]           pc0_q, pc0_d, pc1_q, pc1_d;
    logic [DATA_WIDTH-1:0] inst0_q, inst0_d, inst1_q, inst1_d;
    logic                  push, pop, issue;

    always_comb begin
        pop        = valid_q & id_ready_i;
        push       = resp_live_q;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        pc0_d      = pc0_q;
        inst0_d    = inst0_q;
        pc1_d      = pc1_q;
        inst1_d    = inst1_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        resp_live_d = 1'b0;
        issue      = 1'b0;

        // Entry 0 is always the head, so a pop shifts entry 1 down.
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    pc0_d   = resp_pc_q;
                    inst0_d = rom_rd_data_i;
                end else begin
                    pc1_d   = resp_pc_q;
                    inst1_d = rom_rd_data_i;
                end
            end
            2'b01: begin
                pc0_d   = pc1_q;
                inst0_d = inst1_q;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    pc0_d   = resp_pc_q;
                    inst0_d = rom_rd_data_i;
                end else begin
                    pc0_d   = pc1_q;
                    inst0_d = inst1_q;
                    pc1_d   = resp_pc_q;
                    inst1_d = rom_rd_data_i;
                end
            end
            default: ;
        endcase

        if (redirect_valid_i) begin
            count_d    = 2'd0;
            fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
            issue = (count_d <= 2'd1);
            if (issue) begin
                resp_live_d = 1'b1;
                resp_pc_d   = fetch_pc_q;
                fetch_pc_d  = fetch_pc_q + 32'd4;
            end
        end

        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fetch_pc_q  <= RESET_PC;
            resp_live_q <= 1'b0;
            resp_pc_q   <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            pc0_q       <= '0;
            pc1_q       <= '0;
            inst0_q     <= '0;
            inst1_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            resp_live_q <= resp_live_d;
            resp_pc_q   <= resp_pc_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            pc0_q       <= pc0_d;
            pc1_q       <= pc1_d;
            inst0_q     <= inst0_d;
            inst1_q     <= inst1_d;
        end
    end

    // The credit rule guarantees a live response never lands on a full FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_ni && resp_live_q && !redirect_valid_i) begin
            assert (count_q != 2'd2);
        end
    end

    assign rom_addr_o = fetch_pc_q[ADDR_WIDTH+1:2];
    assign id_valid_o = valid_q;
    assign id_pc_o    = pc0_q;
    assign id_inst_o  = inst0_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random traffic, all checked each
// cycle against a queue-based model of the fetch pipeline and output buffer.
module tb_inst_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redir, ready;
    logic [31:0] rpc;

    logic [9:0]  rom_addr, w_rom_addr;
    logic [31:0] rom_q, w_rom_q;
    logic        id_valid, w_id_valid;
    logic [31:0] id_pc, w_id_pc, id_inst, w_id_inst;

    inst_fetch #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rom_addr_o(rom_addr), .rom_rd_data_i(rom_q),
        .redirect_valid_i(redir), .redirect_pc_i(rpc), .id_valid_o(id_valid),
        .id_ready_i(ready), .id_pc_o(id_pc), .id_inst_o(id_inst));

    inst_fetch #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(32'h0000_0FF8)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .rom_addr_o(w_rom_addr), .rom_rd_data_i(w_rom_q),
        .redirect_valid_i(redir), .redirect_pc_i(rpc), .id_valid_o(w_id_valid),
        .id_ready_i(ready), .id_pc_o(w_id_pc), .id_inst_o(w_id_inst));

    // ROM contents mem[i] = 0x100 + i, one-cycle registered read
    always @(posedge clk) begin
        rom_q   <= 32'h100 + {22'd0, rom_addr};
        w_rom_q <= 32'h100 + {22'd0, w_rom_addr};
    end

    int tests = 0;
    int fails = 0;

    logic [31:0] m_fifo[$];
    logic [31:0] m_infl[$];
    logic [31:0] m_fpc;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h100 + {22'd0, pc[11:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rd);
        rst_n = r; redir = rv; rpc = rp; ready = rd;
        @(posedge clk);
        if (!r) begin
            m_fifo.delete(); m_infl.delete(); m_fpc = 32'h0;
        end else if (rv) begin
            m_fifo.delete(); m_infl.delete(); m_fpc = rp & 32'hFFFF_FFFC;
        end else begin
            if (m_fifo.size() > 0 && rd) void'(m_fifo.pop_front());
            if (m_infl.size() > 0) m_fifo.push_back(m_infl.pop_front());
            if (m_fifo.size() <= 1) begin
                m_infl.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
        #1;
        chk("model_valid", {31'd0, id_valid}, {31'd0, m_fifo.size() != 0});
        chk("model_rom_addr", {22'd0, rom_addr}, {22'd0, m_fpc[11:2]});
        chk("model_fifo_depth", {31'd0, m_fifo.size() > 2}, 32'd0);
        if (m_fifo.size() != 0) begin
            chk("model_pc", id_pc, m_fifo[0]);
            chk("model_inst", id_inst, rom_word(m_fifo[0]));
        end
    endtask

    logic [9:0]  a0;
    logic [31:0] w_ra_exp[5];
    logic [31:0] w_pc_exp[5];
    logic [31:0] w_in_exp[5];

    initial begin
        rst_n = 1'b0; redir = 1'b0; rpc = '0; ready = 1'b1;
        w_ra_exp = '{32'h3FE, 32'h3FF, 32'h000, 32'h001, 32'h002};
        w_pc_exp = '{32'h0, 32'h0, 32'hFF8, 32'hFFC, 32'h1000};
        w_in_exp = '{32'h0, 32'h0, 32'h4FE, 32'h4FF, 32'h100};

        // reset, then cold start
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'h0);
        chk("rst_inst", id_inst, 32'h0);
        chk("rst_rom_addr", {22'd0, rom_addr}, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("cold_c1_valid", {31'd0, id_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("cold_c2_valid", {31'd0, id_valid}, 32'd1);
        chk("cold_c2_pc", id_pc, 32'h0);
        chk("cold_c2_inst", id_inst, 32'h100);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("stream_pc8", id_pc, 32'h8);
        chk("stream_inst8", id_inst, 32'h102);

        // redirect to 0x43 while offering pc 0x8
        step(1'b1, 1'b1, 32'h43, 1'b1);
        chk("redir_c1_valid", {31'd0, id_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_c2_valid", {31'd0, id_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_tgt_pc", id_pc, 32'h40);
        chk("redir_tgt_inst", id_inst, 32'h110);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_next_pc", id_pc, 32'h44);
        chk("redir_next_inst", id_inst, 32'h111);

        // backpressure while offering 0x10
        step(1'b1, 1'b1, 32'h10, 1'b1);
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("bp_start_pc", id_pc, 32'h10);
        a0 = rom_addr;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0);
            chk("bp_hold_pc", id_pc, 32'h10);
            chk("bp_hold_inst", id_inst, 32'h104);
        end
        chk("bp_rom_adv_le2", {31'd0, (rom_addr - a0) <= 10'd2}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            chk("bp_resume_pc", id_pc, 32'h14 + 32'(4 * i));
        end

        // redirect while the buffer is full
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 32'h20, 1'b1);
        chk("full_redir_valid1", {31'd0, id_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("full_redir_valid2", {31'd0, id_valid}, 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("full_redir_pc", id_pc, 32'h20);
        chk("full_redir_inst", id_inst, 32'h108);

        // reset mid-run with full buffer; wrap instance observed on restart
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("midrst_valid", {31'd0, id_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(1'b1, 1'b0, 32'h0, 1'b1);
            chk("wrap_rom_addr", {22'd0, w_rom_addr}, w_ra_exp[i]);
            if (i >= 2) begin
                chk("wrap_valid", {31'd0, w_id_valid}, 32'd1);
                chk("wrap_pc", w_id_pc, w_pc_exp[i]);
                chk("wrap_inst", w_id_inst, w_in_exp[i]);
            end
        end
        chk("midrst_restart_pc", id_pc, 32'h8);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, rv, rd;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 99) >= 2);
            rv  = ($urandom_range(0, 99) < 6);
            rd  = ($urandom_range(0, 99) < 65);
            tgt = $urandom;
            step(r, rv, tgt, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
